// File: rtl/interrupt_controller.sv
// -----------------------------------------------------------------------------
// interrupt_controller
//
// Front end of the interrupt path. It synchronises the asynchronous interrupt
// pin and detects rising edges. It holds one pending request. When no
// call/ret/branch hazard sits in fetch or decode, it pulses o_interrupt_call.
// It then injects a micro-sequence into decode: PUSH_PC, an optional
// PUSH_FLAGS, and JUMP to VECTOR_ADDR. Finally it drains for DRAIN_CYCLES
// before it takes another request.
//
// Build option:
//   INT_SAVE_FLAGS_EN  defined   : sequence is PUSH_PC, PUSH_FLAGS, JUMP
//                      undefined : sequence is PUSH_PC, JUMP (op 01 never driven)
//
// Ports:
//   i_clk              clock, rising edge
//   i_rst_n            asynchronous active-low reset
//   i_int              external interrupt pin (asynchronous, rising-edge sensitive)
//   i_stall_interrupt  hazard instruction present in fetch or decode
//   i_flush_f_d        branch/ret flush in progress this cycle
//   i_stall_d_em       decode->EX/MEM stalled, injected op not accepted
//   o_interrupt_call   one-cycle pulse when the sequence starts
//   o_freeze_fetch     holds PC and F/D register while ops are injected
//   o_inject_valid     o_inject_op is valid
//   o_inject_op        00 PUSH_PC, 01 PUSH_FLAGS, 10 JUMP
//   o_vector_addr      VECTOR_ADDR while JUMP is presented, otherwise 0
//   o_busy             high in every state except IDLE and WAIT_SAFE
//   o_pending          a captured interrupt is waiting for service
//   o_dbg_state        current FSM state, for observation only
//
// Injection handshake: o_inject_valid acts as valid and !i_stall_d_em acts as
// ready. An op transfers in a cycle where both are high. While it waits, the
// op and the valid signal stay unchanged. After a transfer, the next op
// appears in the following cycle.
// -----------------------------------------------------------------------------
module interrupt_controller #(
   parameter int unsigned          ADDR_W       = 32,
   parameter logic [ADDR_W-1:0]    VECTOR_ADDR  = '0,
   parameter int unsigned          SYNC_STAGES  = 2,
   parameter int unsigned          DRAIN_CYCLES = 3
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_int,
   input  logic              i_stall_interrupt,
   input  logic              i_flush_f_d,
   input  logic              i_stall_d_em,
   output logic              o_interrupt_call,
   output logic              o_freeze_fetch,
   output logic              o_inject_valid,
   output logic [1:0]        o_inject_op,
   output logic [ADDR_W-1:0] o_vector_addr,
   output logic              o_busy,
   output logic              o_pending,
   output logic [2:0]        o_dbg_state
);

   localparam logic [1:0] OP_PUSH_PC    = 2'b00;
`ifdef INT_SAVE_FLAGS_EN
   localparam logic [1:0] OP_PUSH_FLAGS = 2'b01;
`endif
   localparam logic [1:0] OP_JUMP       = 2'b10;

   // The counter is loaded on the JUMP accept. DRAIN then lasts exactly
   // DRAIN_CYCLES cycles and leaves on the cycle where the count is zero.
   localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_WAIT_SAFE = 3'd1,
      ST_PUSH_PC   = 3'd2,
      ST_JUMP      = 3'd4,
      ST_DRAIN     = 3'd5
`ifdef INT_SAVE_FLAGS_EN
      , ST_PUSH_FLAGS = 3'd3
`endif
   } state_t;

   state_t                 state_q, state_d;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_prev_q;
   logic                   int_edge;
   logic                   pending_q;
   logic [3:0]             drain_q;
   logic                   drain_load;
   logic                   call;

   // Synchroniser. New samples enter at bit 0. The oldest sample sits at the MSB.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_q      <= '0;
         sync_prev_q <= 1'b0;
      end else begin
         sync_q      <= {sync_q[SYNC_STAGES-2:0], i_int};
         sync_prev_q <= sync_q[SYNC_STAGES-1];
      end
   end

   assign int_edge = sync_q[SYNC_STAGES-1] & ~sync_prev_q;

   // The pending request is a single slot. The call clears it. An edge in the
   // call cycle sets it again, so that edge is not lost.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         pending_q <= 1'b0;
      end else begin
         pending_q <= (pending_q & ~call) | int_edge;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         drain_q <= '0;
      end else if (drain_load) begin
         drain_q <= DRAIN_LOAD;
      end else if (state_q == ST_DRAIN && drain_q != '0) begin
         drain_q <= drain_q - 4'd1;
      end
   end

   always_comb begin
      state_d        = state_q;
      call           = 1'b0;
      o_inject_valid = 1'b0;
      o_inject_op    = OP_PUSH_PC;
      o_freeze_fetch = 1'b0;
      o_busy         = 1'b0;
      drain_load     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (pending_q) state_d = ST_WAIT_SAFE;
         end
         ST_WAIT_SAFE: begin
            if (!i_stall_interrupt && !i_flush_f_d) begin
               call    = 1'b1;
               state_d = ST_PUSH_PC;
            end
         end
         ST_PUSH_PC: begin
            o_inject_valid = 1'b1;
            o_inject_op    = OP_PUSH_PC;
            o_freeze_fetch = 1'b1;
            o_busy         = 1'b1;
`ifdef INT_SAVE_FLAGS_EN
            if (!i_stall_d_em) state_d = ST_PUSH_FLAGS;
`else
            if (!i_stall_d_em) state_d = ST_JUMP;
`endif
         end
`ifdef INT_SAVE_FLAGS_EN
         ST_PUSH_FLAGS: begin
            o_inject_valid = 1'b1;
            o_inject_op    = OP_PUSH_FLAGS;
            o_freeze_fetch = 1'b1;
            o_busy         = 1'b1;
            if (!i_stall_d_em) state_d = ST_JUMP;
         end
`endif
         ST_JUMP: begin
            o_inject_valid = 1'b1;
            o_inject_op    = OP_JUMP;
            o_freeze_fetch = 1'b1;
            o_busy         = 1'b1;
            if (!i_stall_d_em) begin
               state_d    = ST_DRAIN;
               drain_load = 1'b1;
            end
         end
         ST_DRAIN: begin
            o_busy = 1'b1;
            if (drain_q == '0) state_d = pending_q ? ST_WAIT_SAFE : ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   assign o_interrupt_call = call;
   assign o_pending        = pending_q;
   assign o_vector_addr    = (state_q == ST_JUMP) ? VECTOR_ADDR : '0;
   assign o_dbg_state      = state_q;

endmodule

// File: tb/tb_interrupt_controller.sv
// -----------------------------------------------------------------------------
// tb_interrupt_controller
//
// Each scenario fills per-cycle input arrays. A transaction-level model works
// out, from those arrays alone, when every call and every accepted injection
// must occur. The model also gives the expected per-cycle pending, busy and
// freeze values. A monitor pops the expected events as the DUT presents them.
// -----------------------------------------------------------------------------
module tb_interrupt_controller;

   localparam int          ADDR_W = 32;
   localparam logic [31:0] VEC    = 32'h0000_0040;
   localparam int          SYNC   = 2;
   localparam int          DRAIN  = 3;
   localparam int          L      = 128;   // cycles per scenario
   localparam int          STIM   = 64;    // random activity only in this prefix
   localparam int          EV_CALL = 4;
`ifdef INT_SAVE_FLAGS_EN
   localparam bit          FLAGS_EN = 1'b1;
   localparam logic [1:0]  MID_OP   = 2'b01;
`else
   localparam bit          FLAGS_EN = 1'b0;
   localparam logic [1:0]  MID_OP   = 2'b00;
`endif

   // ---------------- clock / reset / DUT ----------------
   logic              i_clk = 1'b0;
   logic              i_rst_n;
   logic              i_int, i_stall_interrupt, i_flush_f_d, i_stall_d_em;
   logic              o_interrupt_call, o_freeze_fetch, o_inject_valid;
   logic [1:0]        o_inject_op;
   logic [ADDR_W-1:0] o_vector_addr;
   logic              o_busy, o_pending;
   logic [2:0]        o_dbg_state;

   always #5 i_clk = ~i_clk;

   interrupt_controller #(
      .ADDR_W(ADDR_W), .VECTOR_ADDR(VEC), .SYNC_STAGES(SYNC), .DRAIN_CYCLES(DRAIN)
   ) dut (
      .i_clk(i_clk), .i_rst_n(i_rst_n), .i_int(i_int),
      .i_stall_interrupt(i_stall_interrupt), .i_flush_f_d(i_flush_f_d),
      .i_stall_d_em(i_stall_d_em), .o_interrupt_call(o_interrupt_call),
      .o_freeze_fetch(o_freeze_fetch), .o_inject_valid(o_inject_valid),
      .o_inject_op(o_inject_op), .o_vector_addr(o_vector_addr), .o_busy(o_busy),
      .o_pending(o_pending), .o_dbg_state(o_dbg_state)
   );

   // ---------------- stimulus arrays, model outputs, scoreboard ----------------
   logic        int_a[L], si_a[L], fl_a[L], sd_a[L];
   logic        exp_pend[L], exp_busy[L], exp_frz[L];
   logic [15:0] exp_q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   bit          run_active = 1'b0;
   logic [15:0] got_ev, exp_ev;

   function automatic logic [15:0] ev(input int c, input int code);
      return 16'((c << 3) | (code & 7));
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: cycle %0d got %0h required %0h", name, cyc, act, req);
      end
   endtask

   // Transaction-level model. A service starts from the first edge at or after
   // the previous call cycle. Pending becomes visible one cycle after the edge
   // is detected. The controller looks at the request one cycle after both it
   // is pending and the previous drain has finished. It calls on the first safe
   // cycle. Each op then transfers on the first unstalled cycle after the
   // previous one.
   task automatic build_model();
      int edges[$];
      int floor_c, decide_t, i, p, ws, c, a, aj;
      logic cur, prv;
      for (int k = 0; k < L; k++) begin
         exp_pend[k] = 1'b0; exp_busy[k] = 1'b0; exp_frz[k] = 1'b0;
      end
      for (int k = SYNC; k < L; k++) begin
         cur = int_a[k-SYNC];
         prv = (k > SYNC) ? int_a[k-SYNC-1] : 1'b0;
         if (cur && !prv) edges.push_back(k);
      end
      floor_c = 0; decide_t = 0; i = 0;
      forever begin
         while (i < edges.size() && edges[i] < floor_c) i++;
         if (i >= edges.size()) break;
         p  = edges[i] + 1;
         ws = ((p > decide_t) ? p : decide_t) + 1;
         c  = ws;
         while (c < L && (si_a[c] || fl_a[c])) c++;
         if (c >= L) break;
         exp_q.push_back(ev(c, EV_CALL));
         for (int k = p; k <= c && k < L; k++) exp_pend[k] = 1'b1;
         a = c + 1; aj = a;
         for (int k = 0; k < 3; k++) begin
            if (k == 1 && !FLAGS_EN) continue;
            while (a < L && sd_a[a]) a++;
            if (a < L) exp_q.push_back(ev(a, k));
            aj = a;
            a++;
         end
         for (int k = c + 1; k <= aj + DRAIN && k < L; k++) exp_busy[k] = 1'b1;
         for (int k = c + 1; k <= aj && k < L; k++) exp_frz[k] = 1'b1;
         decide_t = aj + DRAIN;
         floor_c  = c;
      end
   endtask

   // ---------------- monitor ----------------
   always @(negedge i_clk) begin
      if (run_active) begin
         chk("pending", 32'(o_pending), 32'(exp_pend[cyc]));
         chk("busy", 32'(o_busy), 32'(exp_busy[cyc]));
         chk("freeze", 32'(o_freeze_fetch), 32'(exp_frz[cyc]));
         if (o_inject_valid && o_inject_op == 2'b10)
            chk("vector_addr", o_vector_addr, VEC);
         if (o_interrupt_call || (o_inject_valid && !i_stall_d_em)) begin
            got_ev = o_interrupt_call ? ev(cyc, EV_CALL) : ev(cyc, int'(o_inject_op));
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL event: got cycle %0d code %0d, required no event",
                        got_ev >> 3, got_ev[2:0]);
            end else begin
               exp_ev = exp_q.pop_front();
               if (got_ev !== exp_ev) begin
                  errors++;
                  $display("FAIL event: got cycle %0d code %0d, required cycle %0d code %0d",
                           got_ev >> 3, got_ev[2:0], exp_ev >> 3, exp_ev[2:0]);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic clear_inputs();
      i_int = 1'b0; i_stall_interrupt = 1'b0; i_flush_f_d = 1'b0; i_stall_d_em = 1'b0;
   endtask

   task automatic clear_arrays();
      for (int k = 0; k < L; k++) begin
         int_a[k] = 1'b0; si_a[k] = 1'b0; fl_a[k] = 1'b0; sd_a[k] = 1'b0;
      end
   endtask

   task automatic do_reset();
      run_active = 1'b0;
      clear_inputs();
      i_rst_n = 1'b0;
      repeat (2) @(posedge i_clk);
      @(negedge i_clk);
      i_rst_n = 1'b1;
   endtask

   task automatic run_scenario(input string name);
      do_reset();
      exp_q.delete();
      build_model();
      for (int c = 0; c < L; c++) begin
         @(posedge i_clk);
         #1;
         cyc               = c;
         i_int             = int_a[c];
         i_stall_interrupt = si_a[c];
         i_flush_f_d       = fl_a[c];
         i_stall_d_em      = sd_a[c];
         run_active        = 1'b1;
      end
      @(posedge i_clk);
      #1;
      run_active = 1'b0;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL %s: got %0d events missing, required 0", name, exp_q.size());
      end
      exp_q.delete();
   endtask

   task automatic reset_mid_sequence();
      bit found;
      do_reset();
      @(posedge i_clk); #1 i_int = 1'b1;
      repeat (3) @(posedge i_clk);
      #1 i_int = 1'b0;
      found = 1'b0;
      for (int k = 0; k < 40 && !found; k++) begin
         @(negedge i_clk);
         if (o_inject_valid && o_inject_op == MID_OP) found = 1'b1;
      end
      chk("reach_mid_op", 32'(found), 32'd1);
      #2 i_rst_n = 1'b0;
      #1;
      chk("rst_call", 32'(o_interrupt_call), 32'd0);
      chk("rst_freeze", 32'(o_freeze_fetch), 32'd0);
      chk("rst_valid", 32'(o_inject_valid), 32'd0);
      chk("rst_op", 32'(o_inject_op), 32'd0);
      chk("rst_vaddr", o_vector_addr, 32'd0);
      chk("rst_busy", 32'(o_busy), 32'd0);
      chk("rst_pending", 32'(o_pending), 32'd0);
      repeat (2) @(posedge i_clk);
      @(negedge i_clk) i_rst_n = 1'b1;
      for (int k = 0; k < 10; k++) begin
         @(negedge i_clk);
         chk("post_rst_valid", 32'(o_inject_valid), 32'd0);
         chk("post_rst_busy", 32'(o_busy), 32'd0);
         chk("post_rst_pending", 32'(o_pending), 32'd0);
         chk("post_rst_call", 32'(o_interrupt_call), 32'd0);
      end
   endtask

   // ---------------- main sequence ----------------
   initial begin
      clear_inputs();
      i_rst_n = 1'b0;
      #12;
      chk("reset_call", 32'(o_interrupt_call), 32'd0);
      chk("reset_valid", 32'(o_inject_valid), 32'd0);
      chk("reset_busy", 32'(o_busy), 32'd0);
      chk("reset_pending", 32'(o_pending), 32'd0);
      chk("reset_freeze", 32'(o_freeze_fetch), 32'd0);
      chk("reset_vaddr", o_vector_addr, 32'd0);

      // basic: one clean edge, no stalls
      clear_arrays();
      for (int k = 0; k < 4; k++) int_a[k] = 1'b1;
      run_scenario("basic");

      // safe point: hazard for 5 cycles, then a flush on the cycle it drops
      clear_arrays();
      for (int k = 0; k < 4; k++) int_a[k] = 1'b1;
      for (int k = 4; k < 9; k++) si_a[k] = 1'b1;
      fl_a[9] = 1'b1;
      run_scenario("safe_point");

      // backpressure on PUSH_PC for 4 cycles
      clear_arrays();
      for (int k = 0; k < 4; k++) int_a[k] = 1'b1;
      for (int k = 5; k < 9; k++) sd_a[k] = 1'b1;
      run_scenario("backpressure");

      // back-to-back: second edge lands during JUMP, third edge is dropped
      clear_arrays();
      int_a[0] = 1'b1; int_a[1] = 1'b1; int_a[4] = 1'b1;
      int_a[6] = 1'b1; int_a[7] = 1'b1;
      run_scenario("back_to_back");

      reset_mid_sequence();

      for (int s = 0; s < 24; s++) begin
         clear_arrays();
         for (int k = 0; k < STIM; k++) begin
            int_a[k] = ($urandom_range(0, 3) == 0);
            si_a[k]  = ($urandom_range(0, 2) == 0);
            fl_a[k]  = ($urandom_range(0, 4) == 0);
            sd_a[k]  = ($urandom_range(0, 2) == 0);
         end
         run_scenario("random");
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
